// File: rtl/sync_glitch_filter_pkg.sv
// sync_glitch_filter_pkg: shared FSM state encoding and counter sizing for the glitch filter
package sync_glitch_filter_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        QUAL_HI   = 2'b01,
        STABLE_HI = 2'b11,
        QUAL_LO   = 2'b10
    } filt_state_t;

    function automatic int cnt_width(input int filt_cyc);
        return $clog2(filt_cyc + 1);
    endfunction

endpackage

// File: rtl/sync_glitch_filter_bit.sv
// sync_glitch_filter_bit: one bit of synchronizer chain, stability FSM and qualification counter
module sync_glitch_filter_bit
    import sync_glitch_filter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 4
) (
    input  logic cp,
    input  logic cdn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(FILT_CYC);
    localparam logic [CW-1:0] LAST = CW'(FILT_CYC - 1);

    logic [SYNC_STAGES-1:0] chain;
    logic                   s;
    filt_state_t            state;
    logic [CW-1:0]          cnt;

    assign s = chain[SYNC_STAGES-1];

    // Pure flop-to-flop shift: nothing between stages so metastability has a full cycle to resolve
    always_ff @(posedge cp or negedge cdn)
        if (!cdn) chain <= '0;
        else      chain <= {chain[SYNC_STAGES-2:0], d};

    always_ff @(posedge cp or negedge cdn) begin
        if (!cdn) begin
            state <= STABLE_LO;
            cnt   <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE_LO:
                    if (s) begin
                        if (FILT_CYC == 1) begin
                            state <= STABLE_HI;
                            q     <= 1'b1;
                            rise  <= 1'b1;
                        end else begin
                            state <= QUAL_HI;
                            cnt   <= CW'(1);
                        end
                    end
                QUAL_HI:
                    if (!s) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= STABLE_HI;
                        q     <= 1'b1;
                        rise  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                STABLE_HI:
                    if (!s) begin
                        if (FILT_CYC == 1) begin
                            state <= STABLE_LO;
                            q     <= 1'b0;
                            fall  <= 1'b1;
                        end else begin
                            state <= QUAL_LO;
                            cnt   <= CW'(1);
                        end
                    end
                QUAL_LO:
                    if (s) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= STABLE_LO;
                        q     <= 1'b0;
                        fall  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                default: state <= STABLE_LO;
            endcase
        end
    end

endmodule

// File: rtl/sync_glitch_filter.sv
// sync_glitch_filter: per-bit synchronizer + glitch filter with RISE/FALL pulses.
// Optional sticky edge flags enabled by defining SYNC_GLITCH_FILTER_STICKY_EN.
module sync_glitch_filter #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 4
) (
    input  logic             CP,
    input  logic             CDN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    input  logic [WIDTH-1:0] STS_CLR,
    output logic [WIDTH-1:0] EDGE_STS
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sync_glitch_filter_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_CYC   (FILT_CYC)
        ) u_bit (
            .cp  (CP),
            .cdn (CDN),
            .d   (D[i]),
            .q   (Q[i]),
            .rise(RISE[i]),
            .fall(FALL[i])
        );
    end

`ifdef SYNC_GLITCH_FILTER_STICKY_EN
    // A new edge outranks a clear arriving in the same cycle
    always_ff @(posedge CP or negedge CDN)
        if (!CDN) EDGE_STS <= '0;
        else      EDGE_STS <= (EDGE_STS & ~STS_CLR) | RISE | FALL;
`else
    logic unused_sts_clr;
    assign unused_sts_clr = ^STS_CLR;
    assign EDGE_STS       = '0;
`endif

endmodule

// File: tb/tb_sync_glitch_filter.sv
// tb_sync_glitch_filter: randomized and directed checks of sync_glitch_filter against a run-length model
module tb_sync_glitch_filter;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int FC = 4;

    logic         CP = 1'b0;
    logic         CDN = 1'b0;
    logic [W-1:0] D = '0;
    logic [W-1:0] STS_CLR = '0;
    logic [W-1:0] Q, RISE, FALL, EDGE_STS;
    logic         D1 = 1'b0;
    logic         Q1, R1, F1, E1;
    int           total = 0;
    int           bad = 0;

    always #5 CP = ~CP;

    sync_glitch_filter #(.WIDTH(W), .SYNC_STAGES(SS), .FILT_CYC(FC)) dut (
        .CP(CP), .CDN(CDN), .D(D), .Q(Q), .RISE(RISE), .FALL(FALL),
        .STS_CLR(STS_CLR), .EDGE_STS(EDGE_STS)
    );

    sync_glitch_filter #(.WIDTH(1), .SYNC_STAGES(2), .FILT_CYC(1)) dut1 (
        .CP(CP), .CDN(CDN), .D(D1), .Q(Q1), .RISE(R1), .FALL(F1),
        .STS_CLR(1'b0), .EDGE_STS(E1)
    );

    // Model: s is D delayed SS samples; Q flips once s has disagreed with Q for FC samples in a row
    logic [W-1:0] hist[$];
    logic [W-1:0] ms;
    logic [W-1:0] mq = '0, mrise = '0, mfall = '0, msts = '0;
    int           run[W];

    always @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            hist = {};
            repeat (SS) hist.push_back('0);
            mq = '0; mrise = '0; mfall = '0; msts = '0;
            for (int i = 0; i < W; i++) run[i] = 0;
        end else begin
            ms = hist.pop_front();
            hist.push_back(D);
`ifdef SYNC_GLITCH_FILTER_STICKY_EN
            msts = (msts & ~STS_CLR) | mrise | mfall;
`endif
            for (int i = 0; i < W; i++) begin
                mrise[i] = 1'b0;
                mfall[i] = 1'b0;
                run[i] = (ms[i] != mq[i]) ? run[i] + 1 : 0;
                if (run[i] == FC) begin
                    mq[i] = ~mq[i];
                    mrise[i] = mq[i];
                    mfall[i] = ~mq[i];
                    run[i] = 0;
                end
            end
        end
    end

    task automatic test_reset;
        CDN = 1'b0;
        D = '0;
        repeat (3) @(negedge CP);
        total++;
        if ({Q, RISE, FALL, EDGE_STS} !== 16'h0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0000", {Q, RISE, FALL, EDGE_STS});
        end
        CDN = 1'b1;
        repeat (4) begin
            @(negedge CP);
            total++;
            if ({Q, RISE, FALL, EDGE_STS} !== {mq, mrise, mfall, msts}) begin
                bad++;
                $display("FAIL reset_model got=%h want=%h", {Q, RISE, FALL, EDGE_STS}, {mq, mrise, mfall, msts});
            end
        end
    endtask

    task automatic test_rise_latency;
        logic eq, er;
        D[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CP);
            eq = (k >= 6);
            er = (k == 6);
            total++;
            if ({Q[0], RISE[0], FALL[0]} !== {eq, er, 1'b0}) begin
                bad++;
                $display("FAIL rise_latency edge=%0d got q/r/f=%b want=%b", k, {Q[0], RISE[0], FALL[0]}, {eq, er, 1'b0});
            end
            total++;
            if ({Q, RISE, FALL, EDGE_STS} !== {mq, mrise, mfall, msts}) begin
                bad++;
                $display("FAIL rise_model edge=%0d got=%h want=%h", k, {Q, RISE, FALL, EDGE_STS}, {mq, mrise, mfall, msts});
            end
        end
    endtask

    task automatic test_glitch;
        logic [1:0] erf;
        D[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CP);
            if (k == 3) D[1] = 1'b0;
            total++;
            if ({Q[1], RISE[1], FALL[1]} !== 3'b000) begin
                bad++;
                $display("FAIL glitch_short edge=%0d got q/r/f=%b want=000", k, {Q[1], RISE[1], FALL[1]});
            end
        end
        D[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge CP);
            if (k == 4) D[1] = 1'b0;
            erf = (k == 6) ? 2'b10 : (k == 10) ? 2'b01 : 2'b00;
            total++;
            if ({RISE[1], FALL[1]} !== erf) begin
                bad++;
                $display("FAIL glitch_4cyc edge=%0d got r/f=%b want=%b", k, {RISE[1], FALL[1]}, erf);
            end
            total++;
            if ({Q, RISE, FALL, EDGE_STS} !== {mq, mrise, mfall, msts}) begin
                bad++;
                $display("FAIL glitch_model edge=%0d got=%h want=%h", k, {Q, RISE, FALL, EDGE_STS}, {mq, mrise, mfall, msts});
            end
        end
    endtask

    task automatic test_opposite;
        logic [W-1:0] eq, er, ef;
        D = 4'b0100;
        repeat (10) @(negedge CP);
        D = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CP);
            eq = (k >= 6) ? 4'b0001 : 4'b0100;
            er = (k == 6) ? 4'b0001 : 4'b0000;
            ef = (k == 6) ? 4'b0100 : 4'b0000;
            total++;
            if ({Q, RISE, FALL} !== {eq, er, ef}) begin
                bad++;
                $display("FAIL opposite edge=%0d got q/r/f=%h want=%h", k, {Q, RISE, FALL}, {eq, er, ef});
            end
        end
    endtask

    task automatic test_async_reset;
        logic [W-1:0] eq, er;
        D = '1;
        repeat (10) @(negedge CP);
        D[0] = 1'b0;
        repeat (4) @(negedge CP);
        total++;
        if (Q !== 4'hF) begin
            bad++;
            $display("FAIL areset_pre got q=%h want=f", Q);
        end
        #2 CDN = 1'b0;
        #1;
        total++;
        if ({Q, RISE, FALL, EDGE_STS} !== 16'h0) begin
            bad++;
            $display("FAIL areset_async got=%h want=0000", {Q, RISE, FALL, EDGE_STS});
        end
        D = '1;
        @(negedge CP);
        CDN = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CP);
            eq = (k >= 6) ? 4'hF : 4'h0;
            er = (k == 6) ? 4'hF : 4'h0;
            total++;
            if ({Q, RISE, FALL} !== {eq, er, 4'h0}) begin
                bad++;
                $display("FAIL areset_release edge=%0d got q/r/f=%h want=%h", k, {Q, RISE, FALL}, {eq, er, 4'h0});
            end
        end
    endtask

    task automatic test_sticky;
        int n;
`ifdef SYNC_GLITCH_FILTER_STICKY_EN
        STS_CLR = '1;
        D = '0;
        repeat (12) @(negedge CP);
        STS_CLR = '0;
        D[3] = 1'b1;
        n = 0;
        do begin @(negedge CP); n++; end while (!RISE[3] && n < 20);
        total++;
        if (RISE[3] !== 1'b1 || EDGE_STS[3] !== 1'b0) begin
            bad++;
            $display("FAIL sticky_rise got r=%b sts=%b want r=1 sts=0", RISE[3], EDGE_STS[3]);
        end
        @(negedge CP);
        total++;
        if (EDGE_STS !== 4'b1000) begin
            bad++;
            $display("FAIL sticky_set got=%b want=1000", EDGE_STS);
        end
        STS_CLR[3] = 1'b1;
        @(negedge CP);
        STS_CLR[3] = 1'b0;
        total++;
        if (EDGE_STS[3] !== 1'b0) begin
            bad++;
            $display("FAIL sticky_clear got=%b want=0", EDGE_STS[3]);
        end
        D[3] = 1'b0;
        repeat (10) @(negedge CP);
        STS_CLR[3] = 1'b1;
        @(negedge CP);
        STS_CLR[3] = 1'b0;
        D[3] = 1'b1;
        n = 0;
        do begin @(negedge CP); n++; end while (!RISE[3] && n < 20);
        STS_CLR[3] = 1'b1;
        @(negedge CP);
        total++;
        if (EDGE_STS[3] !== 1'b1) begin
            bad++;
            $display("FAIL sticky_set_wins got=%b want=1", EDGE_STS[3]);
        end
        @(negedge CP);
        STS_CLR[3] = 1'b0;
        total++;
        if (EDGE_STS[3] !== 1'b0) begin
            bad++;
            $display("FAIL sticky_clear2 got=%b want=0", EDGE_STS[3]);
        end
`else
        for (n = 0; n < 16; n++) begin
            @(negedge CP);
            D = W'($urandom);
            STS_CLR = W'($urandom);
            total++;
            if (EDGE_STS !== 4'h0) begin
                bad++;
                $display("FAIL sticky_off got=%h want=0", EDGE_STS);
            end
        end
`endif
    endtask

    task automatic test_random;
        for (int k = 0; k < 400; k++) begin
            @(negedge CP);
            total++;
            if ({Q, RISE, FALL, EDGE_STS} !== {mq, mrise, mfall, msts}) begin
                bad++;
                $display("FAIL random_model cyc=%0d got=%h want=%h", k, {Q, RISE, FALL, EDGE_STS}, {mq, mrise, mfall, msts});
            end
            total++;
            if ((RISE & FALL) !== 4'h0) begin
                bad++;
                $display("FAIL random_both cyc=%0d got=%h want=0", k, RISE & FALL);
            end
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 5) == 0) D[i] = ~D[i];
            STS_CLR = W'($urandom);
        end
        STS_CLR = '0;
    endtask

    task automatic test_filt1;
        logic eq, er, ef;
        D1 = 1'b0;
        repeat (5) @(negedge CP);
        D1 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CP);
            eq = (k >= 3);
            er = (k == 3);
            total++;
            if ({Q1, R1, F1} !== {eq, er, 1'b0}) begin
                bad++;
                $display("FAIL filt1_rise edge=%0d got q/r/f=%b want=%b", k, {Q1, R1, F1}, {eq, er, 1'b0});
            end
        end
        D1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CP);
            eq = (k < 3);
            ef = (k == 3);
            total++;
            if ({Q1, R1, F1} !== {eq, 1'b0, ef}) begin
                bad++;
                $display("FAIL filt1_fall edge=%0d got q/r/f=%b want=%b", k, {Q1, R1, F1}, {eq, 1'b0, ef});
            end
        end
        D1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CP);
            D1 = 1'b0;
            eq = (k == 3);
            er = (k == 3);
            ef = (k == 4);
            total++;
            if ({Q1, R1, F1} !== {eq, er, ef}) begin
                bad++;
                $display("FAIL filt1_pulse edge=%0d got q/r/f=%b want=%b", k, {Q1, R1, F1}, {eq, er, ef});
            end
        end
        total++;
        if (E1 !== 1'b0 && E1 !== 1'b1) begin
            bad++;
            $display("FAIL filt1_sts got=%b want=0/1", E1);
        end
    endtask

    initial begin
        test_reset;
        test_rise_latency;
        test_glitch;
        test_opposite;
        test_async_reset;
        test_sticky;
        test_random;
        test_filt1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
